ps2_text_buffer_ctrl: RTL and testbench

Keyboard-to-text-line controller between the PS2_controller and the VGA character-ROM text overlay. It filters PS/2 make codes, decodes letters A–J and digits 0–9 into character-ROM addresses, and writes them into a one-line register buffer. It manages the write cursor, backspace, and a space-key "new run" that clears the line and advances a BCD run counter. The VGA text path reads the buffer by column with the same 1-cycle latency as the character ROM.

---
 rtl/ps2_text_buffer_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_ps2_text_buffer_ctrl.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_text_buffer_ctrl.sv
// PS/2 make-code to one-line text buffer for the VGA character-ROM overlay.
// Optional feature: define TEXT_BUF_BACKSPACE_EN to enable the 0x66 backspace key.
module ps2_text_buffer_ctrl #(
   parameter int BUF_DEPTH = 16,
   parameter int ADDR_W    = 4
) (
   input  logic              CLOCK_50_I,
   input  logic              resetn,
   input  logic [7:0]        PS2_code,
   input  logic              PS2_code_ready,
   input  logic              PS2_make_code,
   input  logic [ADDR_W-1:0] rd_col,
   output logic [5:0]        rd_char,
   output logic [ADDR_W:0]   char_count,
   output logic [7:0]        run_bcd,
   output logic              buf_full,
   output logic              clear_busy
);

   localparam logic [5:0] BLANK    = 6'o40;
   localparam logic [1:0] K_NONE   = 2'd0;
   localparam logic [1:0] K_CHAR   = 2'd1;
   localparam logic [1:0] K_NEWRUN = 2'd2;
`ifdef TEXT_BUF_BACKSPACE_EN
   localparam logic [1:0] K_BKSP   = 2'd3;
`endif

   typedef enum logic [1:0] {IDLE, DECODE, WRITE, CLEAR} state_t;

   state_t            state, next_state;
   logic              ready_p0, make_p0, ready_buf;
   logic [7:0]        code_p0, code_reg;
   logic              ev;
   logic [7:0]        dec;
   logic [1:0]        kind;
   logic [5:0]        val;
   logic [ADDR_W-1:0] cnt_idx, clr_idx, wr_idx;
   logic              wr_en;
   logic [5:0]        wr_data;
   logic [5:0]        cells [BUF_DEPTH];

   // Returns {kind, character-ROM address}.
   function automatic logic [7:0] decode(input logic [7:0] c);
      case (c)
         8'h1C: decode = {K_CHAR, 6'o01};
         8'h32: decode = {K_CHAR, 6'o02};
         8'h21: decode = {K_CHAR, 6'o03};
         8'h23: decode = {K_CHAR, 6'o04};
         8'h24: decode = {K_CHAR, 6'o05};
         8'h2B: decode = {K_CHAR, 6'o06};
         8'h34: decode = {K_CHAR, 6'o07};
         8'h33: decode = {K_CHAR, 6'o10};
         8'h43: decode = {K_CHAR, 6'o11};
         8'h3B: decode = {K_CHAR, 6'o12};
         8'h45: decode = {K_CHAR, 6'o60};
         8'h16: decode = {K_CHAR, 6'o61};
         8'h1E: decode = {K_CHAR, 6'o62};
         8'h26: decode = {K_CHAR, 6'o63};
         8'h25: decode = {K_CHAR, 6'o64};
         8'h2E: decode = {K_CHAR, 6'o65};
         8'h36: decode = {K_CHAR, 6'o66};
         8'h3D: decode = {K_CHAR, 6'o67};
         8'h3E: decode = {K_CHAR, 6'o70};
         8'h46: decode = {K_CHAR, 6'o71};
         8'h29: decode = {K_NEWRUN, BLANK};
`ifdef TEXT_BUF_BACKSPACE_EN
         8'h66: decode = {K_BKSP, BLANK};
`endif
         default: decode = {K_NONE, 6'o00};
      endcase
   endfunction

   function automatic logic [7:0] bcd_inc(input logic [7:0] b);
      if (b[3:0] == 4'd9)
         bcd_inc = {(b[7:4] == 4'd9) ? 4'd0 : b[7:4] + 4'd1, 4'd0};
      else
         bcd_inc = {b[7:4], b[3:0] + 4'd1};
   endfunction

   assign ev         = ready_p0 & ~ready_buf & make_p0;
   assign dec        = decode(code_reg);
   assign kind       = dec[7:6];
   assign val        = dec[5:0];
   assign cnt_idx    = char_count[ADDR_W-1:0];
   assign buf_full   = (char_count == (ADDR_W+1)'(BUF_DEPTH));

   // Stage p0: input sample; ready_buf: previous sample for edge detect
   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         ready_p0  <= 1'b0;
         make_p0   <= 1'b0;
         code_p0   <= 8'h00;
         ready_buf <= 1'b0;
         code_reg  <= 8'h00;
      end else begin
         ready_p0  <= PS2_code_ready;
         make_p0   <= PS2_make_code;
         code_p0   <= PS2_code;
         ready_buf <= ready_p0;
         if (state == IDLE && ev)
            code_reg <= code_p0;
      end
   end

   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) state <= IDLE;
      else         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE:   if (ev) next_state = DECODE;
         DECODE: begin
            next_state = IDLE;
            if (kind == K_CHAR && !buf_full)  next_state = WRITE;
            if (kind == K_NEWRUN)             next_state = CLEAR;
`ifdef TEXT_BUF_BACKSPACE_EN
            if (kind == K_BKSP && char_count != '0) next_state = WRITE;
`endif
         end
         WRITE:  next_state = IDLE;
         CLEAR:  if (clr_idx == '1) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_comb begin
      wr_en      = 1'b0;
      wr_idx     = cnt_idx;
      wr_data    = val;
      clear_busy = 1'b0;
      case (state)
         WRITE: begin
            wr_en = 1'b1;
`ifdef TEXT_BUF_BACKSPACE_EN
            if (kind == K_BKSP) begin
               wr_idx  = cnt_idx - ADDR_W'(1);
               wr_data = BLANK;
            end
`endif
         end
         CLEAR: begin
            wr_en      = 1'b1;
            wr_idx     = clr_idx;
            wr_data    = BLANK;
            clear_busy = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         char_count <= '0;
         run_bcd    <= 8'h00;
         clr_idx    <= '0;
      end else begin
         clr_idx <= (state == CLEAR) ? clr_idx + ADDR_W'(1) : '0;
         if (state == DECODE && next_state == CLEAR)
            run_bcd <= bcd_inc(run_bcd);
         if (state == CLEAR && clr_idx == '1)
            char_count <= '0;
         else if (state == WRITE) begin
`ifdef TEXT_BUF_BACKSPACE_EN
            if (kind == K_BKSP) char_count <= char_count - (ADDR_W+1)'(1);
            else                char_count <= char_count + (ADDR_W+1)'(1);
`else
            char_count <= char_count + (ADDR_W+1)'(1);
`endif
         end
      end
   end

   // Read sees the pre-write value when the same cell is written this cycle
   always_ff @(posedge CLOCK_50_I or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < BUF_DEPTH; i++) cells[i] <= BLANK;
         rd_char <= BLANK;
      end else begin
         if (wr_en) cells[wr_idx] <= wr_data;
         rd_char <= cells[rd_col];
      end
   end

endmodule

// File: tb/tb_ps2_text_buffer_ctrl.sv
// Directed scoreboard bench for ps2_text_buffer_ctrl (honours TEXT_BUF_BACKSPACE_EN).
module tb_ps2_text_buffer_ctrl;

   localparam logic [5:0] BLANK = 6'o40;

   logic       CLOCK_50_I = 1'b0;
   logic       resetn;
   logic [7:0] PS2_code;
   logic       PS2_code_ready;
   logic       PS2_make_code;
   logic [3:0] rd_col;
   logic [5:0] rd_char;
   logic [4:0] char_count;
   logic [7:0] run_bcd;
   logic       buf_full;
   logic       clear_busy;

   ps2_text_buffer_ctrl #(.BUF_DEPTH(16), .ADDR_W(4)) dut (
      .CLOCK_50_I(CLOCK_50_I), .resetn(resetn), .PS2_code(PS2_code),
      .PS2_code_ready(PS2_code_ready), .PS2_make_code(PS2_make_code),
      .rd_col(rd_col), .rd_char(rd_char), .char_count(char_count),
      .run_bcd(run_bcd), .buf_full(buf_full), .clear_busy(clear_busy)
   );

   always #10 CLOCK_50_I = ~CLOCK_50_I;

   int checks = 0;
   int errors = 0;
   logic [5:0] exp_buf [16];
   int exp_cnt;
   int exp_runs;
   logic [5:0] sb [$];
   logic [7:0] key_codes [20] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43, 8'h3B,
                                  8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [6:0] ref_decode(input logic [7:0] c);
      ref_decode = 7'd0;
      for (int i = 0; i < 10; i++) begin
         if (c == key_codes[i])      ref_decode = {1'b1, 6'(i + 1)};
         if (c == key_codes[i + 10]) ref_decode = {1'b1, 6'(48 + i)};
      end
   endfunction

   function automatic logic [7:0] exp_run();
      return {4'((exp_runs % 100) / 10), 4'(exp_runs % 10)};
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) exp_buf[i] = BLANK;
      exp_cnt  = 0;
      exp_runs = 0;
   endtask

   task automatic model_key(input logic [7:0] c);
      logic [6:0] r;
      r = ref_decode(c);
      if (r[6]) begin
         if (exp_cnt < 16) begin
            exp_buf[exp_cnt] = r[5:0];
            exp_cnt++;
         end
      end else if (c == 8'h29) begin
         for (int i = 0; i < 16; i++) exp_buf[i] = BLANK;
         exp_cnt = 0;
         exp_runs++;
      end
`ifdef TEXT_BUF_BACKSPACE_EN
      else if (c == 8'h66 && exp_cnt > 0) begin
         exp_cnt--;
         exp_buf[exp_cnt] = BLANK;
      end
`endif
   endtask

   task automatic press(input logic [7:0] c, input logic m);
      @(negedge CLOCK_50_I);
      PS2_code = c; PS2_make_code = m; PS2_code_ready = 1'b1;
      repeat (2) @(negedge CLOCK_50_I);
      PS2_code_ready = 1'b0;
      repeat (22) @(negedge CLOCK_50_I);
      if (m) model_key(c);
   endtask

   task automatic rd_check(input string tag, input int col);
      logic [5:0] e;
      @(negedge CLOCK_50_I);
      rd_col = 4'(col);
      sb.push_back(exp_buf[col]);
      @(posedge CLOCK_50_I);
      #1;
      e = sb.pop_front();
      chk(tag, 32'(rd_char), 32'(e));
   endtask

   task automatic check_status(input string tag);
      chk({tag, "_count"}, 32'(char_count), 32'(exp_cnt));
      chk({tag, "_run"},   32'(run_bcd),    32'(exp_run()));
      chk({tag, "_full"},  32'(buf_full),   32'(exp_cnt == 16));
   endtask

   initial begin
      int old_cnt, c2, c3, busy_n, first_busy;
      logic [7:0] run_at2;
      bit seen;

      resetn = 1'b0; PS2_code = 8'h00; PS2_code_ready = 1'b0; PS2_make_code = 1'b0; rd_col = 4'd0;
      model_reset();
      repeat (3) @(negedge CLOCK_50_I);
      chk("rst_count", 32'(char_count), 0);
      chk("rst_run",   32'(run_bcd),    0);
      chk("rst_full",  32'(buf_full),   0);
      chk("rst_busy",  32'(clear_busy), 0);
      chk("rst_rdchar", 32'(rd_char),   32'(BLANK));
      resetn = 1'b1;

      // A, 5, then J with write-latency observation
      press(8'h1C, 1'b1);
      press(8'h2E, 1'b1);
      @(negedge CLOCK_50_I);
      old_cnt = char_count;
      PS2_code = 8'h3B; PS2_make_code = 1'b1; PS2_code_ready = 1'b1;
      c2 = 0; c3 = 0;
      for (int i = 0; i < 24; i++) begin
         @(negedge CLOCK_50_I);
         if (i == 1) PS2_code_ready = 1'b0;
         if (i == 2) c2 = char_count;
         if (i == 3) c3 = char_count;
      end
      model_key(8'h3B);
      chk("lat_n2", 32'(c2), 32'(old_cnt));
      chk("lat_n3", 32'(c3), 32'(old_cnt + 1));
      check_status("abc");
      chk("abc_count_const", 32'(char_count), 3);
      rd_check("cell0_A", 0);
      rd_check("cell1_5", 1);
      rd_check("cell2_J", 2);
      rd_check("cell3_blank", 3);

      // Space: observe clear sweep length and run counter timing
      @(negedge CLOCK_50_I);
      PS2_code = 8'h29; PS2_make_code = 1'b1; PS2_code_ready = 1'b1;
      busy_n = 0; first_busy = -1; run_at2 = 8'hFF;
      for (int i = 0; i < 40; i++) begin
         @(negedge CLOCK_50_I);
         if (i == 1) PS2_code_ready = 1'b0;
         if (i == 2) run_at2 = run_bcd;
         if (clear_busy) begin
            busy_n++;
            if (first_busy < 0) first_busy = i;
         end
      end
      model_key(8'h29);
      chk("busy_len",   32'(busy_n),     16);
      chk("busy_start", 32'(first_busy), 2);
      chk("run_at_n2",  32'(run_at2),    32'h01);
      check_status("space");
      for (int i = 0; i < 16; i++) rd_check("cleared_cell", i);

      // 17 printable keys: last one dropped
      for (int i = 0; i < 17; i++) press(key_codes[i], 1'b1);
      check_status("fill");
      chk("fill_full_const", 32'(buf_full), 1);
      rd_check("fill_cell0", 0);
      rd_check("fill_cell15", 15);

      // Backspace behaviour
      press(8'h29, 1'b1);
      press(8'h32, 1'b1);
      press(8'h21, 1'b1);
      press(8'h66, 1'b1);
`ifdef TEXT_BUF_BACKSPACE_EN
      chk("bksp_count_const", 32'(char_count), 1);
`else
      chk("bksp_count_const", 32'(char_count), 2);
`endif
      check_status("bksp");
      rd_check("bksp_cell1", 1);
      press(8'h66, 1'b1);
      press(8'h66, 1'b1);
      press(8'h66, 1'b1);
      check_status("bksp_empty");
      rd_check("bksp_cell0", 0);

      // Break codes are ignored; a long-held strobe is a single event
      press(8'hF0, 1'b0);
      press(8'h1C, 1'b0);
      check_status("break");
      @(negedge CLOCK_50_I);
      PS2_code = 8'h1C; PS2_make_code = 1'b1; PS2_code_ready = 1'b1;
      repeat (1000) @(negedge CLOCK_50_I);
      PS2_code_ready = 1'b0;
      repeat (22) @(negedge CLOCK_50_I);
      model_key(8'h1C);
      check_status("held");

      // Reset during the clear sweep
      press(8'h24, 1'b1);
      @(negedge CLOCK_50_I);
      PS2_code = 8'h29; PS2_make_code = 1'b1; PS2_code_ready = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge CLOCK_50_I);
         if (i == 1) PS2_code_ready = 1'b0;
         if (clear_busy) seen = 1'b1;
      end
      PS2_code_ready = 1'b0;
      chk("clear_seen", 32'(seen), 1);
      repeat (5) @(posedge CLOCK_50_I);
      #1 resetn = 1'b0;
      #1;
      model_reset();
      chk("mid_rst_busy", 32'(clear_busy), 0);
      chk("mid_rst_rdchar", 32'(rd_char), 32'(BLANK));
      check_status("mid_rst");
      @(negedge CLOCK_50_I);
      resetn = 1'b1;
      rd_check("post_rst_cell0", 0);
      rd_check("post_rst_cell1", 1);

      // BCD run counter carries and wraps
      for (int i = 0; i < 100; i++) begin
         press(8'h29, 1'b1);
         if (i == 9) chk("run_10", 32'(run_bcd), 32'h10);
      end
      check_status("run_wrap");
      chk("run_wrap_const", 32'(run_bcd), 32'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
